// File: rtl/vi_pi_stage.sv
// Sequential PI control stage: one shared multiplier forms the P and I terms,
// with a clamped integrator. Optional conditional integration: VI_PI_ANTIWINDUP_EN.
module vi_pi_stage #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int ACC_W   = 32,
  parameter int FRAC    = 12,
  parameter int INT_LIM = 1073741823,
  parameter int OUT_LIM = 32767
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ref_val,
  input  logic [DATA_W-1:0] meas_val,
  input  logic [COEF_W-1:0] kp,
  input  logic [COEF_W-1:0] ki,
  input  logic              clear_int,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  u_raw,
  output logic [ACC_W-1:0]  int_val,
  output logic              busy
);

  localparam int PROD_W = DATA_W + 1 + COEF_W;

  localparam logic signed [ACC_W:0]   INT_HI = (ACC_W+1)'(INT_LIM);
  localparam logic signed [ACC_W:0]   INT_LO = -INT_HI;
  localparam logic signed [ACC_W-1:0] OUT_HI = ACC_W'(OUT_LIM);
  localparam logic signed [ACC_W-1:0] OUT_LO = ACC_W'(-OUT_LIM - 32'sd1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Elaboration-time guard on the parameter set.
  if (ACC_W < DATA_W + COEF_W + 1 - FRAC || INT_LIM <= 0 || OUT_LIM <= 0) begin : g_bad_cfg
    $error("vi_pi_stage: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_PMUL = 3'd2,
    S_IMUL = 3'd3,
    S_SUM  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  ref_q, meas_q;
  logic signed [COEF_W-1:0]  kp_q, ki_q;
  logic signed [DATA_W:0]    err_q;
  logic signed [ACC_W:0]     p_q;
  logic signed [ACC_W-1:0]   integ_q, integ_d;
  logic signed [ACC_W-1:0]   u_raw_q, u_raw_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [DATA_W:0]    err_s;
  logic signed [COEF_W-1:0]  coef_s;
  logic signed [PROD_W-1:0]  prod_s, shr_s;
  logic signed [ACC_W:0]     term_s;
  logic signed [ACC_W:0]     integ_sum_s;
  logic signed [ACC_W-1:0]   integ_clamp_s;
  logic signed [ACC_W:0]     u_sum_s;
  logic signed [ACC_W-1:0]   u_clamp_s;
  logic                      aw_block_s;
  logic                      accept_s;

  assign accept_s = (state_q == S_IDLE) && in_valid;

  // Datapath: exact error, shared multiplier, and the two clamped adders.
  always_comb begin
    err_s  = (DATA_W+1)'(ref_q) - (DATA_W+1)'(meas_q);
    coef_s = (state_q == S_PMUL) ? kp_q : ki_q;
    prod_s = err_q * coef_s;
    shr_s  = prod_s >>> FRAC;
    term_s = (ACC_W+1)'(shr_s);

    integ_sum_s = (ACC_W+1)'(integ_q) + term_s;
    if (integ_sum_s > INT_HI) begin
      integ_clamp_s = ACC_W'(INT_HI);
    end else if (integ_sum_s < INT_LO) begin
      integ_clamp_s = ACC_W'(INT_LO);
    end else begin
      integ_clamp_s = ACC_W'(integ_sum_s);
    end

    u_sum_s = p_q + (ACC_W+1)'(integ_q);
    if (u_sum_s[ACC_W] == u_sum_s[ACC_W-1]) begin
      u_clamp_s = ACC_W'(u_sum_s);
    end else if (u_sum_s[ACC_W]) begin
      u_clamp_s = ACC_MIN;
    end else begin
      u_clamp_s = ACC_MAX;
    end
  end

`ifdef VI_PI_ANTIWINDUP_EN
  // Freeze integration while the last command is already pushing into saturation.
  always_comb begin
    if ((u_raw_q > OUT_HI) && (term_s > 0)) begin
      aw_block_s = 1'b1;
    end else if ((u_raw_q < OUT_LO) && (term_s < 0)) begin
      aw_block_s = 1'b1;
    end else begin
      aw_block_s = 1'b0;
    end
  end
`else
  assign aw_block_s = 1'b0;
`endif

  // Next state, integrator update and output register control.
  always_comb begin
    state_d     = state_q;
    u_raw_d     = u_raw_q;
    out_valid_d = out_valid_q;
    integ_d     = integ_q;

    if (clear_int) begin
      integ_d = '0;
    end else if ((state_q == S_IMUL) && !aw_block_s) begin
      integ_d = integ_clamp_s;
    end else begin
      integ_d = integ_q;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR:  state_d = S_PMUL;
      S_PMUL: state_d = S_IMUL;
      S_IMUL: state_d = S_SUM;
      S_SUM: begin
        u_raw_d     = u_clamp_s;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State, operand capture and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ref_q       <= '0;
      meas_q      <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      err_q       <= '0;
      p_q         <= '0;
      integ_q     <= '0;
      u_raw_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      integ_q     <= integ_d;
      u_raw_q     <= u_raw_d;
      out_valid_q <= out_valid_d;
      if (accept_s) begin
        ref_q  <= ref_val;
        meas_q <= meas_val;
        kp_q   <= kp;
        ki_q   <= ki;
      end
      if (state_q == S_ERR) begin
        err_q <= err_s;
      end
      if (state_q == S_PMUL) begin
        p_q <= term_s;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign u_raw     = u_raw_q;
  assign int_val   = integ_q;

endmodule

// File: tb/tb_vi_pi_stage.sv
// Directed self-checking bench for vi_pi_stage; a second instance with
// INT_LIM=1000 shares all inputs and is used for the integrator clamp case.
module tb_vi_pi_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, clear_int, out_ready;
  logic signed [15:0] ref_val, meas_val, kp, ki;
  logic               in_ready, out_valid, busy;
  logic signed [31:0] u_raw, int_val;
  logic               in_ready2, out_valid2, busy2;
  logic signed [31:0] u_raw2, int_val2;

  int checks = 0;
  int errors = 0;

  vi_pi_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ref_val(ref_val), .meas_val(meas_val), .kp(kp), .ki(ki),
    .clear_int(clear_int), .out_valid(out_valid), .out_ready(out_ready),
    .u_raw(u_raw), .int_val(int_val), .busy(busy)
  );

  vi_pi_stage #(.INT_LIM(1000)) dut_lim (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .ref_val(ref_val), .meas_val(meas_val), .kp(kp), .ki(ki),
    .clear_int(clear_int), .out_valid(out_valid2), .out_ready(out_ready),
    .u_raw(u_raw2), .int_val(int_val2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample; return once out_valid is seen (or the budget expires, lat=0).
  task automatic send(input logic signed [15:0] r, input logic signed [15:0] m,
                      input logic signed [15:0] p, input logic signed [15:0] i,
                      output int lat, output logic signed [31:0] iv_pre);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ref_val = r; meas_val = m; kp = p; ki = i;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    iv_pre = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) iv_pre = int_val;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear_int = 1'b1;
    step();
    clear_int = 1'b0;
  endtask

  int                 lat;
  int                 bad;
  int                 seen;
  logic signed [31:0] ivp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear_int = 1'b0; out_ready = 1'b1;
    ref_val = '0; meas_val = '0; kp = '0; ki = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_u_raw", u_raw, 0);
    chk("rst_int_val", int_val, 0);

    // Proportional path
    send(16'sd1000, 16'sd200, 16'sd4096, 16'sd0, lat, ivp);
    chk("p_latency", lat, 4);
    chk("p_u_raw", u_raw, 800);
    chk("p_int_val", int_val, 0);
    step();
    chk("p_hs_out_valid", out_valid, 0);
    chk("p_hs_in_ready", in_ready, 1);

    // Integrator accumulation: 100 * 0.5 per sample
    for (int s = 1; s <= 3; s++) begin
      send(16'sd100, 16'sd0, 16'sd0, 16'sd2048, lat, ivp);
      chk("i_latency", lat, 4);
      chk("i_u_raw", u_raw, 50 * s);
      chk("i_int_val", int_val, 50 * s);
      if (s == 1) chk("i_int_before_valid", ivp, 50);
      step();
    end
    pulse_clear();
    chk("clear_int_val", int_val, 0);
    chk("clear_int_val_lim", int_val2, 0);

    // Floor rounding
    send(16'sd0, 16'sd1, 16'sd2048, 16'sd0, lat, ivp);
    chk("floor_neg_u_raw", u_raw, -1);
    step();
    send(16'sd0, -16'sd1, 16'sd2048, 16'sd0, lat, ivp);
    chk("floor_pos_u_raw", u_raw, 0);
    step();

    // Integrator clamp on the INT_LIM=1000 instance
    send(16'sd600, 16'sd0, 16'sd0, 16'sd4096, lat, ivp);
    chk("clamp1_int_val", int_val2, 600);
    chk("clamp1_u_raw", u_raw2, 600);
    step();
    send(16'sd600, 16'sd0, 16'sd0, 16'sd4096, lat, ivp);
    chk("clamp2_int_val", int_val2, 1000);
    chk("clamp2_u_raw", u_raw2, 1000);
    chk("noclamp_int_val", int_val, 1200);
    step();
    pulse_clear();

    // Backpressure: output held, extra in_valid ignored
    out_ready = 1'b0;
    send(16'sd1000, 16'sd200, 16'sd4096, 16'sd0, lat, ivp);
    chk("bp_u_raw", u_raw, 800);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      ref_val = -16'sd5;
      in_valid = 1'b1;
      step();
      if (u_raw !== 32'sd800 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("bp_stable_cycles_bad", bad, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);
    step();
    chk("bp_no_stale_accept", busy, 0);

    // Reset in PMUL aborts the sample
    ref_val = 16'sd1000; meas_val = 16'sd200; kp = 16'sd4096; ki = 16'sd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_u_raw", u_raw, 0);
    chk("mrst_int_val", int_val, 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("mrst_no_output", seen, 0);

    // Anti-windup scenario
    send(16'sd30000, 16'sd0, 16'sd4096, 16'sd4096, lat, ivp);
    chk("aw1_u_raw", u_raw, 60000);
    chk("aw1_int_val", int_val, 30000);
    step();
    send(16'sd30000, 16'sd0, 16'sd4096, 16'sd4096, lat, ivp);
`ifdef VI_PI_ANTIWINDUP_EN
    chk("aw2_int_val", int_val, 30000);
    chk("aw2_u_raw", u_raw, 60000);
`else
    chk("aw2_int_val", int_val, 60000);
    chk("aw2_u_raw", u_raw, 90000);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
